// File: rtl/simd_pkg.sv
// Shared types and sizing for the SIMD instruction packer.
package simd_pkg;

   localparam int SIMD_NUM = 64;
   localparam int GROUP_W  = 8;
   localparam int ADDR_W   = 6;

   typedef struct packed {
      logic              op;
      logic              tag;
      logic [ADDR_W-1:0] addr;
   } simd_group_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      ISSUE
   } state_t;

endpackage

// File: rtl/popcount64.sv
// Population count of a bit vector; sized for the 64 tag bits of one word.
module popcount64 #(
   parameter int N  = 64,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  vec,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + {{(CW-1){1'b0}}, vec[i]};
      end
   end

endmodule

// File: rtl/simd_instr_packer.sv
// Packs per-core records into a SIMD_NUM-group instruction word and issues it.
// Optional INSTR_TIMEOUT_EN force-issues a partial word after TIMEOUT idle cycles.
module simd_instr_packer
   import simd_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [5:0]                  in_core,
   input  logic                        in_op,
   input  logic                        in_tag,
   input  logic [ADDR_W-1:0]           in_addr,
   input  logic                        in_flush,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [SIMD_NUM*GROUP_W-1:0] instr,
   output logic [SIMD_NUM-1:0]         instr_mask,
   output logic [CNT_W-1:0]            agg_done_cnt,
   output logic                        busy
);

   localparam int IDX_W = $clog2(SIMD_NUM);
   localparam int PC_W  = $clog2(SIMD_NUM + 1);

   state_t                      state_q, state_d;
   logic [SIMD_NUM-1:0]         mask_q, mask_d, acc_mask, tag_vec;
   simd_group_t [SIMD_NUM-1:0]  grp_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [IDX_W-1:0]            core_idx;
   logic                        core_ok, hit, accept, retire, timeout_hit;
   logic [PC_W-1:0]             tag_cnt;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   assign core_idx = in_core[IDX_W-1:0];
   assign core_ok  = (32'(in_core) < SIMD_NUM);
   // A record for an occupied slot stalls the producer and forces the issue.
   assign hit      = in_valid && core_ok && mask_q[core_idx];
   assign in_ready = (state_q != ISSUE) && !hit;
   assign accept   = in_valid && in_ready && core_ok;
   assign retire   = (state_q == ISSUE) && instr_ready;
   assign acc_mask = mask_q | (accept ? ({{(SIMD_NUM-1){1'b0}}, 1'b1} << core_idx) : '0);

   always_comb begin
      state_d = state_q;
      mask_d  = retire ? '0 : acc_mask;
      case (state_q)
         IDLE, FILL: begin
            if ((accept && (&acc_mask)) || hit || (in_flush && (|acc_mask)) || timeout_hit)
               state_d = ISSUE;
            else if (|acc_mask)
               state_d = FILL;
            else
               state_d = IDLE;
         end
         ISSUE:   if (instr_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mask_q  <= '0;
         grp_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         if (retire)
            grp_q <= '0;
         else if (accept)
            grp_q[core_idx] <= '{op: in_op, tag: in_tag, addr: in_addr};
         if (retire)
            cnt_q <= sat_add(cnt_q, tag_cnt);
      end
   end

   for (genvar i = 0; i < SIMD_NUM; i++) begin : g_tag
      assign tag_vec[i] = grp_q[i].tag & mask_q[i];
   end

   popcount64 #(.N(SIMD_NUM), .CW(PC_W)) u_popcount (
      .vec   (tag_vec),
      .count (tag_cnt)
   );

`ifdef INSTR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] idle_q;

   always_ff @(posedge clk) begin
      if (rst || accept || (state_q != FILL))
         idle_q <= '0;
      else
         idle_q <= idle_q + 1'b1;
   end

   assign timeout_hit = (state_q == FILL) && !accept && (idle_q == TO_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_hit    = 1'b0;
`endif

   assign instr        = grp_q;
   assign instr_mask   = mask_q;
   assign instr_valid  = (state_q == ISSUE);
   assign agg_done_cnt = cnt_q;
   assign busy         = (|mask_q) || instr_valid;

endmodule

// File: tb/tb_simd_instr_packer.sv
// Scoreboard bench for simd_instr_packer: expected words queued at stimulus, checked at issue.
module tb_simd_instr_packer;
   import simd_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [5:0]   in_core = '0;
   logic         in_op = 1'b0;
   logic         in_tag = 1'b0;
   logic [5:0]   in_addr = '0;
   logic         in_flush = 1'b0;
   logic         instr_valid;
   logic         instr_ready = 1'b1;
   logic [511:0] instr;
   logic [63:0]  instr_mask;
   logic [15:0]  agg_done_cnt;
   logic         busy;

   typedef struct {
      logic [511:0] w;
      logic [63:0]  m;
      int           cnt;
   } item_t;

   item_t        sb_q[$];
   int           checks = 0;
   int           errors = 0;
   int           model_cnt = 0;
   logic [511:0] w_exp;
   logic [63:0]  m_exp;
   int           tags_exp;
   bit           cnt_pend = 0;
   int           cnt_exp;

   simd_instr_packer dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_core      (in_core),
      .in_op        (in_op),
      .in_tag       (in_tag),
      .in_addr      (in_addr),
      .in_flush     (in_flush),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .instr_mask   (instr_mask),
      .agg_done_cnt (agg_done_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic exp_clear();
      w_exp = '0; m_exp = '0; tags_exp = 0;
   endtask

   task automatic exp_add(input int c, input bit op, input bit tag, input logic [5:0] addr);
      w_exp[8*c +: 8] = {op, tag, addr};
      m_exp[c] = 1'b1;
      tags_exp += int'(tag);
   endtask

   task automatic exp_push();
      item_t it;
      model_cnt += tags_exp;
      it.w = w_exp; it.m = m_exp; it.cnt = model_cnt;
      sb_q.push_back(it);
   endtask

   // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic send(input int c, input bit op, input bit tag, input logic [5:0] addr,
                       output int waits);
      in_valid = 1'b1; in_core = 6'(c); in_op = op; in_tag = tag; in_addr = addr;
      waits = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            break;
         end
         waits++;
         if (waits > 200) begin
            chk("send_timeout", 512'(waits), 512'(0));
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic flush();
      in_flush = 1'b1;
      @(posedge clk); #1;
      in_flush = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_instr", instr, '0);
      chk("rst_mask", 512'(instr_mask), '0);
      chk("rst_valid", 512'(instr_valid), '0);
      chk("rst_cnt", 512'(agg_done_cnt), '0);
      chk("rst_busy", 512'(busy), '0);
      rst = 1'b0;
      model_cnt = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (cnt_pend) begin
            chk("agg_cnt", 512'(agg_done_cnt), 512'(cnt_exp));
            cnt_pend = 0;
         end
         if (instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_issue", 512'(1), 512'(0));
            end else begin
               item_t it;
               it = sb_q.pop_front();
               chk("issue_mask", 512'(instr_mask), 512'(it.m));
               chk("issue_word", instr, it.w);
               cnt_pend = 1;
               cnt_exp  = it.cnt;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      cycles(3);
      do_reset();
      chk("idle_ready", 512'(in_ready), 512'(1));

      // Full word of 64 records.
      exp_clear();
      for (int i = 0; i < 64; i++) exp_add(i, i[0], 1'b0, 6'(i));
      exp_push();
      for (int i = 0; i < 64; i++) send(i, i[0], 1'b0, 6'(i), w);
      chk("full_valid", 512'(instr_valid), 512'(1));
      chk("full_ready_low", 512'(in_ready), 512'(0));
      cycles(1);
      chk("full_retired", 512'(instr_valid), 512'(0));
      chk("full_ready_back", 512'(in_ready), 512'(1));

      // Partial word via flush.
      exp_clear();
      exp_add(3, 1'b1, 1'b1, 6'h11);
      exp_add(5, 1'b0, 1'b0, 6'h22);
      exp_push();
      send(3, 1'b1, 1'b1, 6'h11, w);
      send(5, 1'b0, 1'b0, 6'h22, w);
      flush();
      chk("flush_valid", 512'(instr_valid), 512'(1));
      cycles(2);
      chk("flush_idle_busy", 512'(busy), 512'(0));

      // Collision on core 7.
      exp_clear(); exp_add(7, 1'b0, 1'b1, 6'h07); exp_push();
      exp_clear(); exp_add(7, 1'b1, 1'b0, 6'h09); exp_push();
      send(7, 1'b0, 1'b1, 6'h07, w);
      send(7, 1'b1, 1'b0, 6'h09, w);
      chk("coll_wait", 512'(w), 512'(2));
      chk("coll_refill_mask", 512'(instr_mask), 512'(64'h80));
      flush();
      cycles(2);

      // Back-pressure hold with 4 live tags.
      do_reset();
      instr_ready = 1'b0;
      exp_clear();
      for (int i = 10; i < 16; i++) exp_add(i, 1'b1, (i < 14), 6'(i));
      exp_push();
      for (int i = 10; i < 16; i++) send(i, 1'b1, (i < 14), 6'(i), w);
      flush();
      for (int k = 0; k < 10; k++) begin
         chk("hold_valid", 512'(instr_valid), 512'(1));
         chk("hold_ready", 512'(in_ready), 512'(0));
         chk("hold_word", instr, w_exp);
         chk("hold_mask", 512'(instr_mask), 512'(m_exp));
         cycles(1);
      end
      chk("hold_cnt_before", 512'(agg_done_cnt), 512'(0));
      instr_ready = 1'b1;
      cycles(2);
      chk("hold_cnt_after", 512'(agg_done_cnt), 512'(4));

      // Reset during FILL discards the partial word.
      for (int i = 0; i < 10; i++) send(40 + i, 1'b0, 1'b1, 6'(i), w);
      chk("fill_busy", 512'(busy), 512'(1));
      do_reset();
      flush();
      cycles(5);
      chk("post_rst_valid", 512'(instr_valid), 512'(0));
      chk("post_rst_busy", 512'(busy), 512'(0));

`ifdef INSTR_TIMEOUT_EN
      exp_clear(); exp_add(20, 1'b0, 1'b1, 6'h2a); exp_push();
      send(20, 1'b0, 1'b1, 6'h2a, w);
      w = 0;
      while (!instr_valid && w < 100) begin
         cycles(1);
         w++;
      end
      chk("timeout_lat", 512'(w), 512'(16));
      cycles(2);
`else
      exp_clear(); exp_add(20, 1'b0, 1'b1, 6'h2a); exp_push();
      send(20, 1'b0, 1'b1, 6'h2a, w);
      cycles(40);
      chk("no_timeout", 512'(instr_valid), 512'(0));
      flush();
      cycles(2);
`endif

      chk("sb_empty", 512'(sb_q.size()), 512'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
